prbs_checker: RTL
=================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 16: consecutive correct bits required in CHECK before entering LOCKED.
REQ-002 Parameter LOSS_ERRORS, default 4: errors in LOCKED, without an intervening run of 8 good bits, that force loss of lock.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 bit_in  input  1  serial bit from the 8-bit LFSR generator, one new feedback bit per valid cycle.
REQ-006 bit_valid  input  1  qualifies bit_in; the block ignores bit_in when low.
REQ-007 clear_cnt  input  1  synchronous clear of err_count.
REQ-008 locked  output  1  high while in LOCKED.
REQ-009 err_pulse  output  1  one-cycle registered pulse per mismatching bit accepted in LOCKED.
REQ-010 err_count  output  16  saturating count of mismatches detected in LOCKED.
REQ-011 state_o  output  2  current FSM state encoding (HUNT=0, CHECK=1, LOCKED=2).

Function
REQ-012 The block SHALL keep an 8-bit shadow register r; predicted bit p = NOT(r[7] XOR r[5] XOR r[4] XOR r[3]), which matches the generator's XNOR feedback.
REQ-013 HUNT: each valid bit SHALL shift in as r <= {r[6:0], bit_in}, with a fill counter counting 0..8.
REQ-014 HUNT: after 8 filled bits, the FSM SHALL go to CHECK only if r != 8'hFF, which is the XNOR lock-up state; on 8'hFF it stays in HUNT and keeps shifting.
REQ-015 CHECK and LOCKED: each valid bit SHALL be compared to p, and r SHALL shift in p (flywheel), never bit_in.
REQ-016 CHECK: a good bit SHALL increment the good-run counter; a mismatch SHALL return the FSM to HUNT with fill=0 and good-run=0.
REQ-017 CHECK -> LOCKED SHALL occur on the valid cycle of the LOCK_COUNT-th consecutive good bit; locked rises on the next clock edge.
REQ-018 LOCKED: a mismatch SHALL assert err_pulse on the following cycle, increment err_count, increment the miss counter and clear the good-run counter.
REQ-019 LOCKED: 8 consecutive good bits SHALL clear the miss counter.
REQ-020 LOCKED: when the miss counter reaches LOSS_ERRORS, the FSM SHALL go to HUNT and locked falls on the next edge; the loss-causing error is still counted and pulsed.
REQ-021 err_count SHALL saturate at 16'hFFFF and never wrap.
REQ-022 If clear_cnt and a counted error occur in the same cycle, err_count SHALL become 1; clear_cnt alone sets it to 0.
REQ-023 clear_cnt SHALL NOT affect FSM state, r, or the miss counter.
REQ-024 If bit_valid is low, all state SHALL hold and err_pulse SHALL be 0.

Reset
REQ-025 On reset the block SHALL set: state HUNT, r=8'h00, fill=0, good-run=0, miss=0, locked=0, err_pulse=0, err_count=0.
REQ-026 Reset asserted mid-lock SHALL drop locked asynchronously; after release, relock requires the full 8 + LOCK_COUNT valid bits.

Structure
REQ-027 A shared package prbs_pkg SHALL hold the state enum (HUNT, CHECK, LOCKED), the 8-bit tap/predict function, and the constant PRBS8_LOCKUP=8'hFF.
REQ-028 The block SHALL be a single module with no sub-modules; an optional 64-bit variant uses the same FSM with taps 63/62/60/59.

Verification
REQ-029 Feed a generator stream from seed 8'h01, continuous valid -> locked high on cycle 8+16+1 after the first valid bit; err_count stays 0 for 1000 bits.
REQ-030 Once locked, flip one bit -> err_pulse for exactly 1 cycle, err_count=1, locked stays high.
REQ-031 Once locked, flip 4 bits spaced 3 apart -> locked falls after the 4th error, err_count=4, then relock without further errors.
REQ-032 Feed 8 ones -> FSM stays in HUNT (8'hFF rejected); then a valid stream -> normal lock.
REQ-033 Toggle bit_valid randomly with a valid stream -> same lock point in valid-bit count, no errors; preload err_count to 16'hFFFF with continuous errors -> it holds at 16'hFFFF.
REQ-034 Assert reset while locked -> locked=0 and err_count=0 immediately; clear_cnt coincident with an error -> err_count=1.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-8 checker: FSM states, lock-up constant, predictor.
package prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] PRBS8_LOCKUP = 8'hFF;

  // Next generator bit from the shadow register (XNOR feedback, taps 8,6,5,4).
  function automatic logic prbs8_predict(input logic [7:0] r);
    return ~(r[7] ^ r[5] ^ r[4] ^ r[3]);
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// PRBS-8 checker: hunts for alignment, qualifies lock, then flywheels and counts bit errors.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT  = 16,
  parameter int LOSS_ERRORS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        clear_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [1:0]  state_o
);

  localparam int GMAX = (LOCK_COUNT > 8) ? LOCK_COUNT : 8;
  localparam int GW   = $clog2(GMAX + 1);
  localparam int MW   = $clog2(LOSS_ERRORS + 1);

  state_t        state, state_n;
  logic [7:0]    r;
  logic [3:0]    fill;
  logic [GW-1:0] good;
  logic [MW-1:0] miss;

  logic       p, mismatch;
  logic [7:0] r_hunt;
  logic       hunt_ok, lock_hit, run8_hit, loss_hit, err_ev;

  assign p        = prbs8_predict(r);
  assign mismatch = (bit_in != p);
  assign r_hunt   = {r[6:0], bit_in};
  // fill >= 7 means this bit completes the 8-bit fill
  assign hunt_ok  = (fill >= 4'd7) && (r_hunt != PRBS8_LOCKUP);
  assign lock_hit = (good == GW'(LOCK_COUNT - 1));
  assign run8_hit = (good == GW'(7));
  assign loss_hit = (miss == MW'(LOSS_ERRORS - 1));
  assign err_ev   = bit_valid && (state == LOCKED) && mismatch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (bit_valid) begin
      case (state)
        HUNT:    if (hunt_ok) state_n = CHECK;
        CHECK:   if (mismatch) state_n = HUNT;
                 else if (lock_hit) state_n = LOCKED;
        LOCKED:  if (mismatch && loss_hit) state_n = HUNT;
        default: state_n = HUNT;
      endcase
    end
  end

  always_comb begin
    locked  = (state == LOCKED);
    state_o = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r    <= '0;
      fill <= '0;
      good <= '0;
      miss <= '0;
    end else if (bit_valid) begin
      case (state)
        HUNT: begin
          r    <= r_hunt;
          good <= '0;
          if (hunt_ok)            fill <= '0;
          else if (fill != 4'd8)  fill <= fill + 4'd1;
        end
        CHECK: begin
          r <= {r[6:0], p};
          if (mismatch) begin
            good <= '0;
          end else if (lock_hit) begin
            good <= '0;
            miss <= '0;
          end else begin
            good <= good + GW'(1);
          end
        end
        LOCKED: begin
          r <= {r[6:0], p};
          if (mismatch) begin
            good <= '0;
            miss <= loss_hit ? '0 : miss + MW'(1);
          end else if (run8_hit) begin
            good <= '0;
            miss <= '0;
          end else begin
            good <= good + GW'(1);
          end
        end
        default: begin
          r    <= '0;
          fill <= '0;
          good <= '0;
          miss <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= err_ev;
      if (clear_cnt)                     err_count <= err_ev ? 16'd1 : '0;
      else if (err_ev && err_count != '1) err_count <= err_count + 16'd1;
    end
  end

endmodule
